weight_loader: RTL and testbench

Byte-serial loader that writes a complete weight set (two hidden neurons × four weights, plus two output-neuron weights) from the host pins into the network's weight registers. It is the writing end of the weight path: the hidden and output neurons consume `weights_o`, and this block produces it. It sits beside `state_mach` in the top level. Frames arrive on the bidirectional pins under a strobe/toggle-ack handshake, are checked with an 8-bit checksum, and are committed atomically.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/pin_sync_edge.sv | 33 +++
 rtl/weight_loader.sv | 156 +++++++++++++++
 tb/tb_weight_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: constants and types shared by the weight path.
//   W_WIDTH       bits per weight (one host byte per weight)
//   NUM_WEIGHTS   weights per frame: hn0 w0..w3, hn1 w0..w3, on w0, on w1
//   INIT_WEIGHTS  power-on weight set, byte k at bits [8k+7:8k]; also used
//                 by the top-level f0-pass weight muxes
//   state_t       weight_loader frame state
package nn_pkg;

  localparam int W_WIDTH     = 8;
  localparam int NUM_WEIGHTS = 10;

  // Bytes {1,2,3,4, 1,2,3,4, 1,2}, byte 0 in the least significant position.
  localparam logic [NUM_WEIGHTS*W_WIDTH-1:0] INIT_WEIGHTS = 80'h02010403020104030201;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CSUM   = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/pin_sync_edge.sv
// pin_sync_edge: brings an asynchronous pin into the clk_i domain through a
// two-flop synchronizer and emits a registered one-cycle pulse per rising edge.
//   clk_i   clock
//   rst_i   asynchronous active-low reset (all flops clear to 0)
//   pin_i   asynchronous pin level
//   edge_o  one-cycle pulse, three clk_i edges after the pin rises
module pin_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic edge_o
);

  logic sync_1;
  logic sync_2;
  logic sync_2_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
      edge_o   <= 1'b0;
    end else begin
      sync_1   <= pin_i;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
      // Registered so that edge_o is a clean flop output.
      edge_o   <= sync_2 & ~sync_2_d;
    end
  end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: byte-serial host loader for the network weight registers.
// A start rise opens a frame, each strobe rise presents one byte on data_i,
// the byte after the last weight is a mod-256 checksum. A matching checksum
// commits the whole shadow copy to weights_o in one cycle; a mismatch sets
// err_o and leaves weights_o alone.
//
// Handshake: the host raises strobe_i with data_i already stable and keeps
// data_i stable until it observes ack_o toggle. ack_o toggles exactly once
// per accepted byte (weights and checksum); ignored strobes get no toggle.
// The host must wait at least 8 cycles after seeing the toggle before the
// next strobe rise.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   en_i              enable; while low, detected edges are dropped, state held
//   start_i           asynchronous frame start pin (rising edge)
//   strobe_i          asynchronous data strobe pin (rising edge)
//   data_i            host byte
//   ack_o             toggle acknowledge
//   weights_o         committed weights, byte k at bits [8k+7:8k]
//   weights_valid_o   a frame has committed since reset
//   busy_o            frame in progress (LOAD, CSUM, COMMIT)
//   done_o            one-cycle commit pulse
//   err_o             sticky checksum failure, cleared by the next frame start
//   state_o           current frame state, for observation
module weight_loader
  import nn_pkg::*;
#(
  parameter int NUM_WEIGHTS = nn_pkg::NUM_WEIGHTS,
  parameter int W_WIDTH     = nn_pkg::W_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           start_i,
  input  logic                           strobe_i,
  input  logic [W_WIDTH-1:0]             data_i,
  output logic                           ack_o,
  output logic [NUM_WEIGHTS*W_WIDTH-1:0] weights_o,
  output logic                           weights_valid_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output state_t                         state_o
);

  localparam int WB    = NUM_WEIGHTS * W_WIDTH;
  localparam int CNT_W = $clog2(NUM_WEIGHTS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WEIGHTS - 1);

  logic               start_e;
  logic               strobe_e;
  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [W_WIDTH-1:0] sum;
  logic [W_WIDTH-1:0] shadow [NUM_WEIGHTS];

  pin_sync_edge u_start_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (start_i),
    .edge_o (start_e)
  );

  pin_sync_edge u_strobe_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (strobe_i),
    .edge_o (strobe_e)
  );

  assign state_o = state;

  // Start always takes priority over a coincident strobe, so a byte arriving
  // with a start edge is discarded.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start_e) next_state = LOAD;
      end
      LOAD: begin
        if (start_e)                           next_state = LOAD;
        else if (strobe_e && (cnt == LAST_IDX)) next_state = CSUM;
      end
      CSUM: begin
        if (start_e)       next_state = LOAD;
        else if (strobe_e) next_state = (data_i == sum) ? COMMIT : IDLE;
      end
      COMMIT: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      sum             <= '0;
      ack_o           <= 1'b0;
      weights_o       <= WB'(INIT_WEIGHTS);
      weights_valid_o <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      for (int k = 0; k < NUM_WEIGHTS; k++) shadow[k] <= '0;
    end else begin
      done_o <= 1'b0;
      if (en_i) begin
        state <= next_state;
        // Derived from next_state so busy_o drops in the same cycle done_o rises.
        busy_o <= (next_state != IDLE);
        unique case (state)
          IDLE: begin
            if (start_e) begin
              err_o <= 1'b0;
              cnt   <= '0;
              sum   <= '0;
              for (int k = 0; k < NUM_WEIGHTS; k++) shadow[k] <= '0;
            end
          end
          LOAD, CSUM: begin
            if (start_e) begin
              cnt <= '0;
              sum <= '0;
              for (int k = 0; k < NUM_WEIGHTS; k++) shadow[k] <= '0;
            end else if (strobe_e) begin
              ack_o <= ~ack_o;
              if (state == LOAD) begin
                for (int k = 0; k < NUM_WEIGHTS; k++) begin
                  if (cnt == CNT_W'(k)) shadow[k] <= data_i;
                end
                sum <= sum + data_i;
                cnt <= cnt + 1'b1;
              end else if (data_i != sum) begin
                err_o <= 1'b1;
              end
            end
          end
          COMMIT: begin
            for (int k = 0; k < NUM_WEIGHTS; k++) begin
              weights_o[k*W_WIDTH +: W_WIDTH] <= shadow[k];
            end
            weights_valid_o <= 1'b1;
            done_o          <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed bench for weight_loader. A transaction-level
// model (byte queue, running sum, expected output levels) is updated by the
// driver tasks; a compare process checks the DUT against it every quiet cycle
// and watches done_o/ack_o continuously. Literal expectations pin the model.
module tb_weight_loader;
  import nn_pkg::*;

  localparam int WB = NUM_WEIGHTS * W_WIDTH;

  // ---------------- clock / reset / DUT ----------------
  logic          clk      = 1'b0;
  logic          rst_i    = 1'b0;
  logic          en_i     = 1'b0;
  logic          start_i  = 1'b0;
  logic          strobe_i = 1'b0;
  logic [7:0]    data_i   = 8'h00;
  logic          ack_o;
  logic [WB-1:0] weights_o;
  logic          weights_valid_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  state_t        state_o;

  always #5 clk = ~clk;

  weight_loader dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .en_i            (en_i),
    .start_i         (start_i),
    .strobe_i        (strobe_i),
    .data_i          (data_i),
    .ack_o           (ack_o),
    .weights_o       (weights_o),
    .weights_valid_o (weights_valid_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .state_o         (state_o)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WB-1:0] m_weights;
  logic          m_valid;
  logic          m_err;
  logic          m_ack;
  logic          m_in_frame;
  logic [7:0]    m_q[$];
  logic [7:0]    m_sum;
  int            m_done = 0;

  task automatic model_reset();
    logic [7:0] init_list [NUM_WEIGHTS];
    init_list = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2};
    for (int k = 0; k < NUM_WEIGHTS; k++) m_weights[k*8 +: 8] = init_list[k];
    m_valid    = 1'b0;
    m_err      = 1'b0;
    m_ack      = 1'b0;
    m_in_frame = 1'b0;
    m_q.delete();
    m_sum      = 8'h00;
  endtask

  task automatic model_start();
    if (en_i) begin
      m_in_frame = 1'b1;
      m_q.delete();
      m_sum = 8'h00;
      m_err = 1'b0;
    end
  endtask

  // ---------------- compare process ----------------
  logic check_en    = 1'b0;
  logic done_prev   = 1'b0;
  logic ack_prev    = 1'b0;
  int   done_seen   = 0;
  int   ack_toggles = 0;

  always @(negedge clk) begin
    if (rst_i) begin
      if (done_o) begin
        done_seen++;
        chkb("done_one_cycle", done_prev, 1'b0);
        chkb("busy_low_with_done", busy_o, 1'b0);
      end
      if (ack_o !== ack_prev) ack_toggles++;
    end
    done_prev = done_o;
    ack_prev  = ack_o;
    if (check_en) begin
      chk ("weights", weights_o, m_weights);
      chkb("valid", weights_valid_o, m_valid);
      chkb("err", err_o, m_err);
      chkb("busy", busy_o, m_in_frame);
      chkb("ack", ack_o, m_ack);
      chki("done_count", done_seen, m_done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    check_en = 1'b0;
    start_i  = 1'b1;
    repeat (6) @(negedge clk);
    start_i  = 1'b0;
    repeat (4) @(negedge clk);
    model_start();
    check_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic want_ack;
    logic commit;
    int   waited;
    check_en = 1'b0;
    want_ack = en_i && m_in_frame;
    commit   = want_ack && (m_q.size() == NUM_WEIGHTS) && (b == m_sum);
    data_i   = b;
    strobe_i = 1'b1;
    if (want_ack) begin
      waited = 0;
      while ((ack_o === m_ack) && (waited < 30)) begin
        @(negedge clk);
        waited++;
      end
      // 3 edges to the detected pulse plus 1 registered cycle to the toggle.
      chki("ack_latency", waited, 4);
      m_ack = ~m_ack;
      if (m_q.size() < NUM_WEIGHTS) begin
        m_q.push_back(b);
        m_sum = m_sum + b;
      end else begin
        m_in_frame = 1'b0;
        if (commit) begin
          for (int k = 0; k < NUM_WEIGHTS; k++) m_weights[k*8 +: 8] = m_q[k];
          m_valid = 1'b1;
          m_done++;
          @(negedge clk);
          chkb("done_latency", done_o, 1'b1);
          chk ("weights_at_done", weights_o, m_weights);
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      repeat (12) @(negedge clk);
    end
    strobe_i = 1'b0;
    repeat (8) @(negedge clk);
    check_en = 1'b1;
  endtask

  task automatic collide(input logic [7:0] b);
    check_en = 1'b0;
    data_i   = b;
    start_i  = 1'b1;
    strobe_i = 1'b1;
    repeat (12) @(negedge clk);
    start_i  = 1'b0;
    strobe_i = 1'b0;
    repeat (8) @(negedge clk);
    model_start();
    check_en = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int k = 0; k < NUM_WEIGHTS; k++) send_byte(base + 8'(k));
    send_byte(m_sum);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk ({tag, "_weights"}, weights_o, 80'h02010403020104030201);
    chkb({tag, "_valid"}, weights_valid_o, 1'b0);
    chkb({tag, "_ack"}, ack_o, 1'b0);
    chkb({tag, "_err"}, err_o, 1'b0);
    chkb({tag, "_busy"}, busy_o, 1'b0);
    chkb({tag, "_done"}, done_o, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  int ack_base;
  int done_base;

  initial begin
    model_reset();
    en_i  = 1'b1;
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check_en = 1'b1;

    // Good frame: 5..14, checksum 0x5F.
    ack_base = ack_toggles; done_base = done_seen;
    do_start();
    for (int k = 0; k < NUM_WEIGHTS; k++) send_byte(8'd5 + 8'(k));
    chki("model_sum_good", int'(m_sum), 8'h5F);
    send_byte(8'h5F);
    chk ("good_weights", weights_o, 80'h0E0D0C0B0A0908070605);
    chkb("good_valid", weights_valid_o, 1'b1);
    chki("good_ack_toggles", ack_toggles - ack_base, 11);
    chki("good_done_pulses", done_seen - done_base, 1);

    // Bad checksum: same bytes, checksum 0x60.
    done_base = done_seen;
    do_start();
    for (int k = 0; k < NUM_WEIGHTS; k++) send_byte(8'd5 + 8'(k));
    send_byte(8'h60);
    chkb("bad_err", err_o, 1'b1);
    chk ("bad_weights_kept", weights_o, 80'h0E0D0C0B0A0908070605);
    chki("bad_no_done", done_seen - done_base, 0);
    do_start();
    chkb("err_cleared_by_start", err_o, 1'b0);

    // Abort: 4 bytes, restart, full frame 0x10..0x19. Its mod-256 sum is 0xCD.
    done_base = done_seen;
    do_start();
    for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k));
    do_start();
    for (int k = 0; k < NUM_WEIGHTS; k++) send_byte(8'h10 + 8'(k));
    chki("model_sum_abort", int'(m_sum), 8'hCD);
    send_byte(m_sum);
    chk ("abort_weights", weights_o, 80'h19181716151413121110);
    chki("abort_done_once", done_seen - done_base, 1);

    // Collision inside a frame: start wins, byte dropped, counter restarts.
    ack_base = ack_toggles;
    do_start();
    for (int k = 0; k < 3; k++) send_byte(8'h20 + 8'(k));
    collide(8'h77);
    chki("collide_no_ack", ack_toggles - ack_base, 3);
    send_frame(8'h30);
    chk ("collide_weights", weights_o, 80'h39383736353433323130);
    chki("collide_total_acks", ack_toggles - ack_base, 14);

    // Collision from IDLE, then a frame.
    ack_base = ack_toggles;
    collide(8'h55);
    chki("collide_idle_no_ack", ack_toggles - ack_base, 0);
    send_frame(8'h40);

    // Strobes while IDLE are ignored.
    ack_base = ack_toggles;
    for (int k = 0; k < 3; k++) send_byte(8'hA0 + 8'(k));
    chki("idle_strobe_no_ack", ack_toggles - ack_base, 0);

    // Enable low inside a frame: strobe dropped, not replayed later.
    do_start();
    send_byte(8'h50);
    send_byte(8'h51);
    en_i = 1'b0;
    send_byte(8'h99);
    en_i = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 2; k < NUM_WEIGHTS; k++) send_byte(8'h50 + 8'(k));
    send_byte(m_sum);
    chk ("enable_weights", weights_o, 80'h59585756555453525150);

    // Reset mid-frame after 6 bytes, then a good frame.
    do_start();
    for (int k = 0; k < 6; k++) send_byte(8'h60 + 8'(k));
    check_en = 1'b0;
    rst_i    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("after_midreset");
    check_en = 1'b1;
    do_start();
    for (int k = 0; k < NUM_WEIGHTS; k++) send_byte(8'd5 + 8'(k));
    send_byte(8'h5F);
    chk ("post_reset_weights", weights_o, 80'h0E0D0C0B0A0908070605);
    chkb("post_reset_valid", weights_valid_o, 1'b1);

    repeat (4) @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
